// File: rtl/ntt_pkg.sv
// Shared NTT datapath constants: coefficient width, modulus table and pipeline latencies.
package ntt_pkg;

  localparam int unsigned W        = 30;
  localparam int unsigned MULT_LAT = 9;
  localparam int unsigned GS_LAT   = MULT_LAT + 2;
  localparam int unsigned NUM_MOD  = 3;

  typedef logic [W-1:0] coeff_t;

  // NTT-friendly primes below 2^30
  localparam coeff_t Q [NUM_MOD] = '{30'd998244353, 30'd469762049, 30'd167772161};

endpackage

// File: rtl/gs_butterfly_if.sv
// Sample-in / result-out bus of one Gentleman-Sande butterfly lane.
interface gs_butterfly_if;
  import ntt_pkg::*;

  logic   in_valid;
  coeff_t a;
  coeff_t b;
  coeff_t w;
  logic   halve;
  logic   out_valid;
  coeff_t A;
  coeff_t B;

  modport master (output in_valid, a, b, w, halve, input out_valid, A, B);
  modport slave  (input in_valid, a, b, w, halve, output out_valid, A, B);
endinterface

// File: rtl/modular_adder.sv
// Registered (a + b) mod q, one cycle latency; operands assumed < q.
module modular_adder
  import ntt_pkg::*;
#(
  parameter int unsigned mod_index = 0
) (
  input  logic   clk,
  input  coeff_t a_i,
  input  coeff_t b_i,
  output coeff_t sum_o
);
  localparam coeff_t QM = Q[mod_index];

  logic [W:0] sum;
  coeff_t     sum_q;

  assign sum   = (W+1)'(a_i) + (W+1)'(b_i);
  assign sum_o = sum_q;

  always_ff @(posedge clk) begin
    sum_q <= (sum >= (W+1)'(QM)) ? W'(sum - (W+1)'(QM)) : W'(sum);
  end
endmodule

// File: rtl/modular_halver.sv
// Combinational x * 2^-1 mod q: odd values borrow one q so the shift stays exact.
module modular_halver
  import ntt_pkg::*;
#(
  parameter int unsigned mod_index = 0
) (
  input  coeff_t x_i,
  output coeff_t y_o
);
  localparam coeff_t QM = Q[mod_index];

  logic [W:0] t;

  assign t   = x_i[0] ? (W+1)'(x_i) + (W+1)'(QM) : (W+1)'(x_i);
  assign y_o = W'(t >> 1);
endmodule

// File: rtl/modular_multiplier.sv
// Pipelined a*b mod q with MULT_LAT cycles latency: product, reduction, then alignment stages.
module modular_multiplier
  import ntt_pkg::*;
#(
  parameter int unsigned mod_index = 0
) (
  input  logic   clk,
  input  coeff_t a_i,
  input  coeff_t b_i,
  output coeff_t p_o
);
  localparam coeff_t QM = Q[mod_index];

  logic [2*W-1:0] prod_q;
  coeff_t         red_q [MULT_LAT-1];

  assign p_o = red_q[MULT_LAT-2];

  always_ff @(posedge clk) begin
    prod_q   <= (2*W)'(a_i) * (2*W)'(b_i);
    red_q[0] <= W'(prod_q % (2*W)'(QM));
    for (int i = 1; i < int'(MULT_LAT) - 1; i++) begin
      red_q[i] <= red_q[i-1];
    end
  end
endmodule

// File: rtl/modular_subtractor.sv
// Registered (a - b) mod q, one cycle latency; operands assumed < q.
module modular_subtractor
  import ntt_pkg::*;
#(
  parameter int unsigned mod_index = 0
) (
  input  logic   clk,
  input  coeff_t a_i,
  input  coeff_t b_i,
  output coeff_t diff_o
);
  localparam coeff_t QM = Q[mod_index];

  logic [W:0] diff;
  coeff_t     diff_q;

  assign diff   = (a_i >= b_i) ? (W+1)'(a_i) - (W+1)'(b_i)
                               : (W+1)'(a_i) + (W+1)'(QM) - (W+1)'(b_i);
  assign diff_o = diff_q;

  always_ff @(posedge clk) begin
    diff_q <= W'(diff);
  end
endmodule

// File: rtl/gs_butterfly.sv
// Gentleman-Sande butterfly: A = (a+b)[/2] mod q, B = ((a-b)*w)[/2] mod q, fixed GS_LAT latency.
module gs_butterfly
  import ntt_pkg::*;
#(
  parameter int unsigned mod_index = 0
) (
  input logic          clk,
  input logic          rst_n,
  gs_butterfly_if.slave bus
);
  coeff_t            s, d, p, s_half, p_half, a_d, b_d;
  coeff_t            w_q, a_q, b_q;
  coeff_t            s_dly_q [MULT_LAT];
  logic [GS_LAT-1:0] vld_q;
  logic [GS_LAT-2:0] hlv_q;

  modular_adder      #(.mod_index(mod_index)) u_add (.clk(clk), .a_i(bus.a), .b_i(bus.b), .sum_o(s));
  modular_subtractor #(.mod_index(mod_index)) u_sub (.clk(clk), .a_i(bus.a), .b_i(bus.b), .diff_o(d));
  modular_multiplier #(.mod_index(mod_index)) u_mul (.clk(clk), .a_i(d), .b_i(w_q), .p_o(p));

  // w waits one cycle for d; s waits out the multiplier
  always_ff @(posedge clk) begin
    w_q        <= bus.w;
    s_dly_q[0] <= s;
    for (int i = 1; i < int'(MULT_LAT); i++) begin
      s_dly_q[i] <= s_dly_q[i-1];
    end
  end

  modular_halver #(.mod_index(mod_index)) u_hs (.x_i(s_dly_q[MULT_LAT-1]), .y_o(s_half));
  modular_halver #(.mod_index(mod_index)) u_hp (.x_i(p), .y_o(p_half));

  assign a_d = hlv_q[GS_LAT-2] ? s_half : s_dly_q[MULT_LAT-1];
  assign b_d = hlv_q[GS_LAT-2] ? p_half : p;

  // Control chains and output registers; A/B only move on a valid sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      hlv_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      vld_q <= {vld_q[GS_LAT-2:0], bus.in_valid};
      hlv_q <= {hlv_q[GS_LAT-3:0], bus.halve};
      if (vld_q[GS_LAT-2]) begin
        a_q <= a_d;
        b_q <= b_d;
      end
    end
  end

  assign bus.out_valid = vld_q[GS_LAT-1];
  assign bus.A         = a_q;
  assign bus.B         = b_q;
endmodule

// File: tb/tb_gs_butterfly.sv
// Directed and random checks of gs_butterfly (mod_index 0) against constants and a reference pipeline.
module tb_gs_butterfly;
  import ntt_pkg::*;

  localparam logic [63:0] QV  = 64'd998244353;
  localparam int unsigned LAT = GS_LAT;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  gs_butterfly_if bus ();
  gs_butterfly #(.mod_index(0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference pipeline: index LAT-1 holds the sample accepted LAT edges ago
  logic   pv [LAT];
  coeff_t pa [LAT];
  coeff_t pb [LAT];
  coeff_t held_a, held_b;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic coeff_t half_m(input logic [63:0] x);
    return 30'(x[0] ? (x + QV) >> 1 : x >> 1);
  endfunction

  function automatic coeff_t gold_a(input coeff_t a, input coeff_t b, input logic h);
    logic [63:0] s;
    s = (64'(a) + 64'(b)) % QV;
    return h ? half_m(s) : 30'(s);
  endfunction

  function automatic coeff_t gold_b(input coeff_t a, input coeff_t b, input coeff_t w, input logic h);
    logic [63:0] dd, pp;
    dd = (64'(a) + QV - 64'(b)) % QV;
    pp = (dd * 64'(w)) % QV;
    return h ? half_m(pp) : 30'(pp);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < int'(LAT); i++) pv[i] = 1'b0;
    held_a = '0;
    held_b = '0;
  endtask

  // One clock: drive, advance the reference, compare valid and held outputs
  task automatic step(input logic v, input coeff_t a, input coeff_t b, input coeff_t w, input logic h);
    bus.in_valid = v;
    bus.a        = a;
    bus.b        = b;
    bus.w        = w;
    bus.halve    = h;
    @(posedge clk);
    for (int i = int'(LAT) - 1; i > 0; i--) begin
      pv[i] = pv[i-1];
      pa[i] = pa[i-1];
      pb[i] = pb[i-1];
    end
    pv[0] = v & rst_n;
    pa[0] = gold_a(a, b, h);
    pb[0] = gold_b(a, b, w, h);
    #1;
    if (pv[LAT-1]) begin
      held_a = pa[LAT-1];
      held_b = pb[LAT-1];
    end
    check("out_valid", 64'(bus.out_valid), 64'(pv[LAT-1]));
    check("A_model", 64'(bus.A), 64'(held_a));
    check("B_model", 64'(bus.B), 64'(held_b));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0);
  endtask

  // Isolated sample: absent one cycle early, present exactly LAT cycles after acceptance
  task automatic directed(input string tag, input coeff_t a, input coeff_t b, input coeff_t w,
                          input logic h, input coeff_t ea, input coeff_t eb);
    step(1'b1, a, b, w, h);
    idle(int'(LAT) - 2);
    check({tag, "_early"}, 64'(bus.out_valid), 64'd0);
    idle(1);
    check({tag, "_vld"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_A"}, 64'(bus.A), 64'(ea));
    check({tag, "_B"}, 64'(bus.B), 64'(eb));
    idle(1);
    check({tag, "_gone"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    int sent;
    coeff_t ra, rb, rw;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    clear_model();
    bus.in_valid = 1'b0;
    bus.a = '0; bus.b = '0; bus.w = '0; bus.halve = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_A", 64'(bus.A), 64'd0);
    check("rst_B", 64'(bus.B), 64'd0);
    rst_n = 1'b1;

    directed("basic",   30'd5, 30'd3, 30'd1, 1'b0, 30'd8, 30'd2);
    directed("neg",     30'd3, 30'd5, 30'd2, 1'b0, 30'd8, 30'd998244349);
    directed("wrap",    30'd998244352, 30'd1, 30'd1, 1'b0, 30'd0, 30'd998244351);
    directed("half_od", 30'd5, 30'd2, 30'd1, 1'b1, 30'd499122180, 30'd499122178);
    directed("half_ev", 30'd6, 30'd2, 30'd1, 1'b1, 30'd4, 30'd2);
    directed("w_zero",  30'd100, 30'd7, 30'd0, 1'b0, 30'd107, 30'd0);
    directed("w_neg1",  30'd10, 30'd3, 30'd998244352, 1'b0, 30'd13, 30'd998244346);

    // Back-to-back with mixed halve, then random traffic with bubbles
    step(1'b1, 30'd5, 30'd2, 30'd1, 1'b1);
    step(1'b1, 30'd5, 30'd2, 30'd1, 1'b0);
    step(1'b1, 30'd6, 30'd2, 30'd1, 1'b1);
    sent = 0;
    while (sent < 200) begin
      ra = 30'($urandom_range(998244352, 0));
      rb = 30'($urandom_range(998244352, 0));
      rw = 30'($urandom_range(998244352, 0));
      if ($urandom_range(3, 0) == 0) begin
        step(1'b0, ra, rb, rw, 1'($urandom_range(1, 0)));
      end else begin
        step(1'b1, ra, rb, rw, 1'($urandom_range(1, 0)));
        sent++;
      end
    end
    idle(int'(LAT) + 1);

    // Reset with five samples in flight
    for (int i = 0; i < 5; i++) step(1'b1, 30'(i + 20), 30'(i), 30'd3, 1'b0);
    idle(2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_A", 64'(bus.A), 64'd0);
    check("mid_rst_B", 64'(bus.B), 64'd0);
    clear_model();
    step(1'b0, '0, '0, '0, 1'b0);
    rst_n = 1'b1;
    directed("post_rst", 30'd5, 30'd3, 30'd1, 1'b0, 30'd8, 30'd2);
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
